// File: rtl/serpent_encrypt_full.sv
// Iterative Serpent-256 block encryptor: one key-schedule step or one cipher round per clock.
// Optional `SERPENT_READY_OUT_EN adds o_ready (high while waiting for a block with keys loaded).
module serpent_encrypt_full (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_master_key_valid,
   input  logic         i_enable_encrypt,
   input  logic [255:0] i_key,
   input  logic [127:0] i_data,
   output logic [127:0] o_data,
   output logic         o_data_valid
`ifdef SERPENT_READY_OUT_EN
   ,
   output logic         o_ready
`endif
);

   localparam logic [31:0] PHI     = 32'h9E3779B9;
   localparam int          NROUNDS = 32;
   localparam int          NKEYS   = 33;

   // Serpent S-boxes packed so that entry k sits at bits [4k+3:4k]
   localparam logic [63:0] SBOX_PACK [8] = '{
      64'hC90724DEB56A1F83, 64'h43D68EB1A50972CF,
      64'h25B04E1DFAC39768, 64'hE57A421D369C8BF0,
      64'hD7E9A4526B0C38F1, 64'h176D8E30C9A4B25F,
      64'h0A3DF19EB6485C27, 64'h6539AC47B28E0FD1
   };

   typedef enum logic [1:0] {IDLE, KEYEXP, READY, ENC} state_t;

   state_t       state;
   logic         kv_q;
   logic         keys_loaded;
   logic [5:0]   cnt;
   logic [31:0]  win [8];
   logic [127:0] subkeys [NKEYS];
   logic [127:0] blk;

   logic         kv_rise;
   logic [31:0]  widx;
   logic [31:0]  n0, n1, n2, n3;
   logic [127:0] key_sub;
   logic [127:0] sx;
   logic [127:0] round_out;

   function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [127:0] sbox_slice(input logic [2:0] sel, input logic [127:0] x);
      logic [127:0] y;
      logic [63:0]  tab;
      logic [3:0]   nib;
      logic [3:0]   v;
      y   = '0;
      tab = SBOX_PACK[sel];
      for (int b = 0; b < 32; b++) begin
         nib        = {x[96+b], x[64+b], x[32+b], x[b]};
         v          = tab[{nib, 2'b00} +: 4];
         y[b]       = v[0];
         y[32+b]    = v[1];
         y[64+b]    = v[2];
         y[96+b]    = v[3];
      end
      return y;
   endfunction

   function automatic logic [127:0] lin_tr(input logic [127:0] x);
      logic [31:0] x0, x1, x2, x3;
      {x3, x2, x1, x0} = x;
      x0 = rol32(x0, 13);
      x2 = rol32(x2, 3);
      x1 = x1 ^ x0 ^ x2;
      x3 = x3 ^ x2 ^ (x0 << 3);
      x1 = rol32(x1, 1);
      x3 = rol32(x3, 7);
      x0 = x0 ^ x1 ^ x3;
      x2 = x2 ^ x3 ^ (x1 << 7);
      x0 = rol32(x0, 5);
      x2 = rol32(x2, 22);
      return {x3, x2, x1, x0};
   endfunction

   assign kv_rise = i_master_key_valid & ~kv_q;

   // win holds w[i-8..i-1]; the four new prekey words chain off each other within one cycle
   always_comb begin
      widx      = {24'd0, cnt, 2'b00};
      n0        = rol32(win[0] ^ win[3] ^ win[5] ^ win[7] ^ PHI ^ widx, 11);
      n1        = rol32(win[1] ^ win[4] ^ win[6] ^ n0 ^ PHI ^ (widx + 32'd1), 11);
      n2        = rol32(win[2] ^ win[5] ^ win[7] ^ n1 ^ PHI ^ (widx + 32'd2), 11);
      n3        = rol32(win[3] ^ win[6] ^ n0 ^ n2 ^ PHI ^ (widx + 32'd3), 11);
      key_sub   = sbox_slice(3'd3 - cnt[2:0], {n3, n2, n1, n0});
      sx        = sbox_slice(cnt[2:0], blk ^ subkeys[cnt]);
      round_out = (cnt == 6'(NROUNDS - 1)) ? (sx ^ subkeys[NKEYS-1]) : lin_tr(sx);
   end

   // A fresh key strobe pre-empts everything; ENC spends one extra edge moving blk to o_data
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         kv_q         <= 1'b0;
         keys_loaded  <= 1'b0;
         cnt          <= '0;
         blk          <= '0;
         o_data       <= '0;
         o_data_valid <= 1'b0;
         for (int j = 0; j < 8; j++) win[j] <= '0;
         for (int k = 0; k < NKEYS; k++) subkeys[k] <= '0;
      end else begin
         kv_q         <= i_master_key_valid;
         o_data_valid <= 1'b0;
         if (kv_rise) begin
            for (int j = 0; j < 8; j++) win[j] <= i_key[32*j +: 32];
            cnt         <= '0;
            keys_loaded <= 1'b0;
            state       <= KEYEXP;
         end else begin
            case (state)
               KEYEXP: begin
                  subkeys[cnt] <= key_sub;
                  for (int j = 0; j < 4; j++) win[j] <= win[j+4];
                  win[4] <= n0;
                  win[5] <= n1;
                  win[6] <= n2;
                  win[7] <= n3;
                  if (cnt == 6'(NKEYS - 1)) begin
                     keys_loaded <= 1'b1;
                     state       <= READY;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
               READY: begin
                  if (i_enable_encrypt && keys_loaded) begin
                     blk   <= i_data;
                     cnt   <= '0;
                     state <= ENC;
                  end
               end
               ENC: begin
                  if (cnt == 6'(NROUNDS)) begin
                     o_data       <= blk;
                     o_data_valid <= 1'b1;
                     state        <= READY;
                  end else begin
                     blk <= round_out;
                     cnt <= cnt + 6'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef SERPENT_READY_OUT_EN
   assign o_ready = (state == READY);
`endif

endmodule

// File: tb/tb_serpent_encrypt_full.sv
// Directed bench for serpent_encrypt_full with an independent table-driven Serpent reference model.
// Define SERPENT_READY_OUT_EN to also exercise o_ready.
module tb_serpent_encrypt_full;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_master_key_valid;
   logic         i_enable_encrypt;
   logic [255:0] i_key;
   logic [127:0] i_data;
   logic [127:0] o_data;
   logic         o_data_valid;
`ifdef SERPENT_READY_OUT_EN
   logic         o_ready;
`endif

   int checks   = 0;
   int failures = 0;

   localparam logic [255:0] KEY_A  = 256'h00112233445566778899aabbccddeeffffeeddccbbaa99887766554433221100;
   localparam logic [255:0] KEY_B  = 256'hdeadbeef0badf00d13579bdf2468ace0fedcba9876543210a5a55a5a3c3cc3c3;
   localparam logic [127:0] DATA_A = 128'h0123456789abcdef0123456789abcdef;
   localparam logic [127:0] DATA_B = 128'hfedcba9876543210cafef00d00c0ffee;

   serpent_encrypt_full dut (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .i_master_key_valid (i_master_key_valid),
      .i_enable_encrypt   (i_enable_encrypt),
      .i_key              (i_key),
      .i_data             (i_data),
      .o_data             (o_data),
      .o_data_valid       (o_data_valid)
`ifdef SERPENT_READY_OUT_EN
      ,
      .o_ready            (o_ready)
`endif
   );

   always #5 i_clk = ~i_clk;

   // Standard Serpent S-box tables, one row per box
   int sbt [8][16] = '{
      '{ 3, 8,15, 1,10, 6, 5,11,14,13, 4, 2, 7, 0, 9,12},
      '{15,12, 2, 7, 9, 0, 5,10, 1,11,14, 8, 6,13, 3, 4},
      '{ 8, 6, 7, 9, 3,12,10,15,13, 1,14, 4, 0,11, 5, 2},
      '{ 0,15,11, 8,12, 9, 6, 3,13, 1, 2, 4,10, 7, 5,14},
      '{ 1,15, 8, 3,12, 0,11, 6, 2, 5, 4,10, 9,14, 7,13},
      '{15, 5, 2,11, 4,10, 9,12, 0, 3,14, 8,13, 6, 7, 1},
      '{ 7, 2,12, 5, 8, 4, 6,11,14, 9, 1,15,13, 3,10, 0},
      '{ 1,13,15, 0,14, 8, 2,11, 7, 4,12,10, 9, 3, 5, 6}
   };

   function automatic logic [31:0] ref_rol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [127:0] ref_sbox(input int s, input logic [127:0] x);
      logic [127:0] y;
      logic [3:0]   v;
      int           nib;
      y = '0;
      for (int b = 0; b < 32; b++) begin
         nib = (x[b] ? 1 : 0) + (x[32+b] ? 2 : 0) + (x[64+b] ? 4 : 0) + (x[96+b] ? 8 : 0);
         v   = 4'(sbt[s][nib]);
         y[b] = v[0]; y[32+b] = v[1]; y[64+b] = v[2]; y[96+b] = v[3];
      end
      return y;
   endfunction

   function automatic logic [127:0] ref_lt(input logic [127:0] x);
      logic [31:0] a, b, c, d;
      a = x[31:0]; b = x[63:32]; c = x[95:64]; d = x[127:96];
      a = ref_rol(a, 13);
      c = ref_rol(c, 3);
      b = b ^ a ^ c;
      d = d ^ c ^ (a << 3);
      b = ref_rol(b, 1);
      d = ref_rol(d, 7);
      a = a ^ b ^ d;
      c = c ^ d ^ (b << 7);
      a = ref_rol(a, 5);
      c = ref_rol(c, 22);
      return {d, c, b, a};
   endfunction

   function automatic logic [127:0] ref_encrypt(input logic [255:0] key, input logic [127:0] pt);
      logic [31:0]  w [140];
      logic [127:0] k [33];
      logic [127:0] blkv;
      for (int j = 0; j < 8; j++) w[j] = key[32*j +: 32];
      for (int i = 0; i < 132; i++)
         w[i+8] = ref_rol(w[i] ^ w[i+3] ^ w[i+5] ^ w[i+7] ^ 32'h9E3779B9 ^ 32'(i), 11);
      for (int n = 0; n < 33; n++)
         k[n] = ref_sbox((((3 - n) % 8) + 8) % 8, {w[4*n+11], w[4*n+10], w[4*n+9], w[4*n+8]});
      blkv = pt;
      for (int r = 0; r < 31; r++) blkv = ref_lt(ref_sbox(r % 8, blkv ^ k[r]));
      return ref_sbox(7, blkv ^ k[31]) ^ k[32];
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_valid(input int max_cycles, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!o_data_valid && n < max_cycles);
   endtask

   task automatic test_reset();
      int pulses;
      i_rst = 1'b1; i_master_key_valid = 1'b0; i_enable_encrypt = 1'b0;
      i_key = '0; i_data = '0;
      repeat (3) step();
      checks++;
      if (o_data !== 128'd0) begin
         failures++; $display("[TB] FAIL reset_o_data: got %h expected 0", o_data);
      end
      checks++;
      if (o_data_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_valid: got %b expected 0", o_data_valid);
      end
      i_rst = 1'b0;
      i_enable_encrypt = 1'b1;
      i_data = DATA_A;
      pulses = 0;
      repeat (40) begin
         step();
         if (o_data_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++; $display("[TB] FAIL idle_enable: got %0d pulses expected 0", pulses);
      end
      i_enable_encrypt = 1'b0;
   endtask

   task automatic test_golden_vector();
      logic [127:0] expv;
      int n;
      int pulses;
      expv = ref_encrypt(KEY_A, DATA_A);
      i_key = KEY_A; i_data = DATA_A;
      i_master_key_valid = 1'b1; i_enable_encrypt = 1'b1;
      pulses = 0;
      repeat (40) begin
         step();
         if (o_data_valid === 1'b1) pulses++;
      end
      i_key = ~KEY_A; i_data = ~DATA_A;
      wait_valid(100, n);
      checks++;
      if (pulses != 0 || n + 40 != 68) begin
         failures++; $display("[TB] FAIL golden_latency: got %0d cycles (%0d early pulses) expected 68", n + 40, pulses);
      end
      i_data = DATA_A;
      checks++;
      if (o_data !== expv) begin
         failures++; $display("[TB] FAIL golden_data: got %h expected %h", o_data, expv);
      end
      step();
      checks++;
      if (o_data_valid !== 1'b0 || o_data !== expv) begin
         failures++; $display("[TB] FAIL golden_hold: got valid=%b data=%h expected valid=0 data=%h", o_data_valid, o_data, expv);
      end
      wait_valid(100, n);
      checks++;
      if (n != 33 || o_data !== expv) begin
         failures++; $display("[TB] FAIL golden_second: got %0d cycles data=%h expected 33 cycles data=%h", n, o_data, expv);
      end
      i_enable_encrypt = 1'b0; i_master_key_valid = 1'b0;
      step();
   endtask

   task automatic test_zero_key_stream();
      logic [127:0] expv;
      int n;
      expv = ref_encrypt('0, '0);
      i_key = '0; i_data = '0;
      i_master_key_valid = 1'b1; i_enable_encrypt = 1'b1;
      wait_valid(200, n);
      checks++;
      if (n != 68 || o_data !== expv) begin
         failures++; $display("[TB] FAIL zero_first: got %0d cycles data=%h expected 68 cycles data=%h", n, o_data, expv);
      end
      for (int b = 0; b < 2; b++) begin
         wait_valid(100, n);
         checks++;
         if (n != 34 || o_data !== expv) begin
            failures++; $display("[TB] FAIL zero_repeat%0d: got %0d cycles data=%h expected 34 cycles data=%h", b, n, o_data, expv);
         end
      end
      i_enable_encrypt = 1'b0; i_master_key_valid = 1'b0;
      step();
   endtask

   task automatic test_rekey_abort();
      logic [127:0] expv;
      int n;
      int pulses;
      expv = ref_encrypt(KEY_B, DATA_B);
      i_key = KEY_A; i_data = DATA_B;
      i_master_key_valid = 1'b1; i_enable_encrypt = 1'b1;
      step();
      i_master_key_valid = 1'b0;
      pulses = 0;
      repeat (44) begin
         step();
         if (o_data_valid === 1'b1) pulses++;
      end
      i_key = KEY_B; i_master_key_valid = 1'b1;
      wait_valid(200, n);
      checks++;
      if (pulses != 0 || n != 68) begin
         failures++; $display("[TB] FAIL rekey_latency: got %0d cycles (%0d early pulses) expected 68", n, pulses);
      end
      checks++;
      if (o_data !== expv) begin
         failures++; $display("[TB] FAIL rekey_data: got %h expected %h", o_data, expv);
      end
      i_enable_encrypt = 1'b0; i_master_key_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_keyexp();
      logic [127:0] expv;
      int n;
      int pulses;
      expv = ref_encrypt(KEY_A, DATA_B);
      i_key = KEY_A; i_data = DATA_B;
      i_master_key_valid = 1'b1;
      repeat (10) step();
      i_rst = 1'b1;
      #1;
      checks++;
      if (o_data !== 128'd0 || o_data_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL midreset_out: got data=%h valid=%b expected 0/0", o_data, o_data_valid);
      end
      i_master_key_valid = 1'b0;
      step();
      i_rst = 1'b0;
      i_enable_encrypt = 1'b1;
      pulses = 0;
      repeat (100) begin
         step();
         if (o_data_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++; $display("[TB] FAIL midreset_nokey: got %0d pulses expected 0", pulses);
      end
      i_master_key_valid = 1'b1;
      wait_valid(200, n);
      checks++;
      if (n != 68 || o_data !== expv) begin
         failures++; $display("[TB] FAIL midreset_reload: got %0d cycles data=%h expected 68 cycles data=%h", n, o_data, expv);
      end
      i_enable_encrypt = 1'b0; i_master_key_valid = 1'b0;
      step();
   endtask

`ifdef SERPENT_READY_OUT_EN
   task automatic test_ready_out();
      i_key = KEY_B; i_data = DATA_A;
      i_master_key_valid = 1'b1; i_enable_encrypt = 1'b0;
      repeat (10) step();
      checks++;
      if (o_ready !== 1'b0) begin
         failures++; $display("[TB] FAIL ready_keyexp: got %b expected 0", o_ready);
      end
      repeat (24) step();
      checks++;
      if (o_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL ready_idle: got %b expected 1", o_ready);
      end
      i_enable_encrypt = 1'b1;
      repeat (5) step();
      checks++;
      if (o_ready !== 1'b0) begin
         failures++; $display("[TB] FAIL ready_enc: got %b expected 0", o_ready);
      end
      i_enable_encrypt = 1'b0; i_master_key_valid = 1'b0;
      repeat (40) step();
   endtask
`endif

   initial begin
      test_reset();
      test_golden_vector();
      test_zero_key_stream();
      test_rekey_abort();
      test_reset_mid_keyexp();
`ifdef SERPENT_READY_OUT_EN
      test_ready_out();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
